// File: rtl/lector_contadores_pkg.sv
// pkg_contador: constants shared by the pop-counter read sequencer.
//   - default sizes of the counter bank (count, data width, index width)
//   - read-reply timeout default
//   - sequencer state encoding
//   - bank reply latency contract: valid_c never arrives in the same cycle as req
package pkg_contador;

   localparam int N_CNT_DEF   = 5;
   localparam int CNT_W_DEF   = 6;
   localparam int IDX_W_DEF   = 3;
   localparam int TIMEOUT_DEF = 8;

   // Earliest cycle (after req) in which the bank may raise valid_c.
   localparam int REPLY_MIN_LAT = 1;

   localparam logic [2:0] ST_IDLE       = 3'd0;
   localparam logic [2:0] ST_WAIT_IDLE  = 3'd1;
   localparam logic [2:0] ST_REQ        = 3'd2;
   localparam logic [2:0] ST_WAIT_VALID = 3'd3;
   localparam logic [2:0] ST_DONE       = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE       = ST_IDLE,
      S_WAIT_IDLE  = ST_WAIT_IDLE,
      S_REQ        = ST_REQ,
      S_WAIT_VALID = ST_WAIT_VALID,
      S_DONE       = ST_DONE
   } state_t;

   // Width of a counter able to hold 0..t-1.
   function automatic int tmo_width(input int t);
      return (t > 1) ? $clog2(t) : 1;
   endfunction

endpackage

// File: rtl/lector_contadores_lc_timeout.sv
// lc_timeout: reply-wait timer for the counter-bank sequencer.
//   clk       in   system clock
//   reset_L   in   asynchronous active-low reset (count -> 0)
//   clr_i     in   restart the wait (count -> 0)
//   inc_i     in   one more cycle waited without a reply
//   expire_o  out  count has reached TIMEOUT-1: this is the last cycle to wait
module lc_timeout
   import pkg_contador::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic reset_L,
   input  logic clr_i,
   input  logic inc_i,
   output logic expire_o
);

   localparam int             TW   = tmo_width(TIMEOUT);
   localparam logic [TW-1:0]  LAST = TW'(TIMEOUT - 1);

   logic [TW-1:0] tmo_q;
   logic [TW-1:0] tmo_d;

   assign expire_o = (tmo_q == LAST);

   // Saturates at LAST so an ignored expire cannot wrap back into a fresh wait.
   always_comb begin
      tmo_d = tmo_q;
      if (clr_i) begin
         tmo_d = '0;
      end else if (inc_i && !expire_o) begin
         tmo_d = tmo_q + TW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end

endmodule

// File: rtl/lector_contadores.sv
// lector_contadores: read sequencer for the pop-counter bank.
// After a start command and once the system reports idle, reads counters
// 0..N_CNT-1 one at a time, streams each reply out, sums them and flags
// counters that do not answer within TIMEOUT cycles.
//   clk        in   system clock
//   reset_L    in   asynchronous active-low reset
//   start      in   one-cycle sweep request (ignored unless idle in S_IDLE)
//   idle       in   system idle; the sweep waits for it once, at the beginning
//   valid_c    in   bank reply valid
//   data_out   in   bank reply count
//   req, idx   out  read request and counter index to the bank
//   busy       out  sweep in progress
//   res_valid  out  one-cycle pulse with res_idx/res_data
//   res_idx    out  index of the result
//   res_data   out  count read, 0 for a counter that timed out
//   total      out  running sum of res_data for the current sweep
//   done       out  one-cycle pulse at the end of the sweep
//   err        out  sticky: a counter timed out during this sweep
//
// state         | meaning
// S_IDLE        | waiting for start; results of the last sweep are held
// S_WAIT_IDLE   | sweep accepted, waiting for the system to go idle
// S_REQ         | req high for cur_idx (single cycle)
// S_WAIT_VALID  | waiting for valid_c or timeout for cur_idx
// S_DONE        | done pulse, back to S_IDLE
//
// Outputs are Moore-style but registered: each is loaded on the edge that
// enters the state in which it must be visible.
module lector_contadores
   import pkg_contador::*;
#(
   parameter int N_CNT   = N_CNT_DEF,
   parameter int CNT_W   = CNT_W_DEF,
   parameter int IDX_W   = IDX_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic               clk,
   input  logic               reset_L,
   input  logic               start,
   input  logic               idle,
   input  logic               valid_c,
   input  logic [CNT_W-1:0]   data_out,
   output logic               req,
   output logic [IDX_W-1:0]   idx,
   output logic               busy,
   output logic               res_valid,
   output logic [IDX_W-1:0]   res_idx,
   output logic [CNT_W-1:0]   res_data,
   output logic [CNT_W+2:0]   total,
   output logic               done,
   output logic               err
);

   localparam int               TOT_W    = CNT_W + 3;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CNT - 1);

   state_t             state_q;
   logic [IDX_W-1:0]   cur_q;
   logic               req_q;
   logic [IDX_W-1:0]   idx_q;
   logic               busy_q;
   logic               res_valid_q;
   logic [IDX_W-1:0]   res_idx_q;
   logic [CNT_W-1:0]   res_data_q;
   logic [TOT_W-1:0]   total_q;
   logic               done_q;
   logic               err_q;

   logic tmo_clr;
   logic tmo_inc;
   logic tmo_expire;

   assign tmo_clr = (state_q == S_REQ);
   assign tmo_inc = (state_q == S_WAIT_VALID) && !valid_c;

   lc_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk      (clk),
      .reset_L  (reset_L),
      .clr_i    (tmo_clr),
      .inc_i    (tmo_inc),
      .expire_o (tmo_expire)
   );

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q     <= S_IDLE;
         cur_q       <= '0;
         req_q       <= 1'b0;
         idx_q       <= '0;
         busy_q      <= 1'b0;
         res_valid_q <= 1'b0;
         res_idx_q   <= '0;
         res_data_q  <= '0;
         total_q     <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         req_q       <= 1'b0;
         res_valid_q <= 1'b0;
         done_q      <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  total_q <= '0;
                  err_q   <= 1'b0;
                  cur_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_WAIT_IDLE;
               end
            end
            S_WAIT_IDLE: begin
               if (idle) begin
                  req_q   <= 1'b1;
                  idx_q   <= cur_q;
                  state_q <= S_REQ;
               end
            end
            S_REQ: begin
               state_q <= S_WAIT_VALID;
            end
            S_WAIT_VALID: begin
               // A reply on the expiring cycle still counts; only a true miss sets err.
               if (valid_c || tmo_expire) begin
                  res_valid_q <= 1'b1;
                  res_idx_q   <= cur_q;
                  if (valid_c) begin
                     res_data_q <= data_out;
                     total_q    <= total_q + TOT_W'(data_out);
                  end else begin
                     res_data_q <= '0;
                     err_q      <= 1'b1;
                  end
                  if (cur_q == LAST_IDX) begin
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= S_DONE;
                  end else begin
                     cur_q   <= cur_q + IDX_W'(1);
                     req_q   <= 1'b1;
                     idx_q   <= cur_q + IDX_W'(1);
                     state_q <= S_REQ;
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign req       = req_q;
   assign idx       = idx_q;
   assign busy      = busy_q;
   assign res_valid = res_valid_q;
   assign res_idx   = res_idx_q;
   assign res_data  = res_data_q;
   assign total     = total_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule
